// File: rtl/rep_mem_pkg.sv
// Shared sizing for the replicated 2R1W memory.
package rep_mem_pkg;

    localparam int unsigned BLOCKSIZE = 10;
    localparam int unsigned ADDR_W    = BLOCKSIZE + 1;
    localparam int unsigned DEPTH     = 2 << BLOCKSIZE;
    localparam int unsigned DATA_W    = 32;

endpackage

// File: rtl/rep_bank_1r1w.sv
// Synchronous 1R1W array with registered read; a same-edge read sees the old word.
module rep_bank_1r1w #(
    parameter int unsigned ADDR_W = 11,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    localparam int unsigned DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];

    // No reset on the array so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/rep_2r1w_mem.sv
// Two-read/one-write memory: writes go to two mirrored banks, each feeding one read port.
module rep_2r1w_mem #(
    parameter int unsigned BLOCKSIZE = rep_mem_pkg::BLOCKSIZE,
    parameter int unsigned DATA_W    = rep_mem_pkg::DATA_W
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en_w1,
    input  logic [BLOCKSIZE:0]   w1_addr,
    input  logic [DATA_W-1:0]    w1_din,
    input  logic [BLOCKSIZE:0]   r1_addr,
    output logic [DATA_W-1:0]    d1,
    input  logic [BLOCKSIZE:0]   r2_addr,
    output logic [DATA_W-1:0]    d2
);

    localparam int unsigned ADDR_W = BLOCKSIZE + 1;
    localparam int unsigned DEPTH  = 2 << BLOCKSIZE;

    logic [DEPTH-1:0]  valid_q;
    logic              rd1_valid_q;
    logic              rd2_valid_q;
    logic              wr_en;
    logic [DATA_W-1:0] rdata_a;
    logic [DATA_W-1:0] rdata_b;

    assign wr_en = en_w1 & ~rst;

    rep_bank_1r1w #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_bank_a (
        .clk   (clk),
        .we    (wr_en),
        .waddr (w1_addr),
        .wdata (w1_din),
        .raddr (r1_addr),
        .rdata (rdata_a)
    );

    rep_bank_1r1w #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_bank_b (
        .clk   (clk),
        .we    (wr_en),
        .waddr (w1_addr),
        .wdata (w1_din),
        .raddr (r2_addr),
        .rdata (rdata_b)
    );

    // Valid bits give logical zero-init; the lookup is the pre-write value, matching the banks.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q     <= '0;
            rd1_valid_q <= 1'b0;
            rd2_valid_q <= 1'b0;
        end else begin
            rd1_valid_q <= valid_q[r1_addr];
            rd2_valid_q <= valid_q[r2_addr];
            if (en_w1) begin
                valid_q[w1_addr] <= 1'b1;
            end
        end
    end

    assign d1 = rd1_valid_q ? rdata_a : '0;
    assign d2 = rd2_valid_q ? rdata_b : '0;

endmodule

// File: tb/tb_rep_2r1w_mem.sv
// Directed and short random checks of rep_2r1w_mem against an associative-array model.
module tb_rep_2r1w_mem;

    localparam int unsigned AW = 11;
    localparam int unsigned DW = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          en_w1 = 1'b0;
    logic [AW-1:0] w1_addr = '0;
    logic [DW-1:0] w1_din = '0;
    logic [AW-1:0] r1_addr = '0;
    logic [AW-1:0] r2_addr = '0;
    logic [DW-1:0] d1;
    logic [DW-1:0] d2;

    int checks   = 0;
    int failures = 0;

    rep_2r1w_mem dut (
        .clk     (clk),
        .rst     (rst),
        .en_w1   (en_w1),
        .w1_addr (w1_addr),
        .w1_din  (w1_din),
        .r1_addr (r1_addr),
        .d1      (d1),
        .r2_addr (r2_addr),
        .d2      (d2)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: entries absent from the map read as zero; reset empties the map.
    logic [DW-1:0] model [int];
    bit            live = 1'b0;

    always @(posedge clk) begin
        logic [DW-1:0] e1;
        logic [DW-1:0] e2;
        if (rst) begin
            e1 = '0;
            e2 = '0;
            model.delete();
            live = 1'b1;
        end else begin
            e1 = model.exists(int'(r1_addr)) ? model[int'(r1_addr)] : '0;
            e2 = model.exists(int'(r2_addr)) ? model[int'(r2_addr)] : '0;
            if (en_w1) model[int'(w1_addr)] = w1_din;
        end
        if (live) begin
            #1;
            check("model_d1", d1, e1);
            check("model_d2", d2, e2);
        end
    end

    task automatic cyc(input logic en, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                       input logic [AW-1:0] ra1, input logic [AW-1:0] ra2);
        en_w1   = en;
        w1_addr = wa;
        w1_din  = wd;
        r1_addr = ra1;
        r2_addr = ra2;
        @(posedge clk);
        #2;
    endtask

    initial begin
        // Reset pulse, outputs zero on the reset edge.
        rst = 1'b1;
        cyc(1'b0, '0, '0, '0, '0);
        check("rst_d1", d1, 32'h0);
        check("rst_d2", d2, 32'h0);
        rst = 1'b0;

        cyc(1'b0, '0, '0, 11'h000, 11'h7FF);
        check("post_rst_d1", d1, 32'h0);
        check("post_rst_d2", d2, 32'h0);
        for (int i = 0; i < 16; i++) begin
            cyc(1'b0, '0, '0, AW'($urandom), AW'($urandom));
            check("empty_d1", d1, 32'h0);
            check("empty_d2", d2, 32'h0);
        end

        // Write then dual read.
        cyc(1'b1, 11'h123, 32'h0000_00A5, '0, '0);
        cyc(1'b0, '0, '0, 11'h123, 11'h123);
        check("dual_d1", d1, 32'h0000_00A5);
        check("dual_d2", d2, 32'h0000_00A5);

        // Read-old collision on a valid entry.
        cyc(1'b1, 11'h045, 32'h11, '0, '0);
        cyc(1'b1, 11'h045, 32'h22, 11'h045, 11'h045);
        check("coll_old_d1", d1, 32'h11);
        check("coll_old_d2", d2, 32'h11);
        cyc(1'b0, '0, '0, 11'h045, '0);
        check("coll_new_d1", d1, 32'h22);

        // Collision on a never-written entry reads zero first.
        cyc(1'b1, 11'h200, 32'hDEAD_BEEF, 11'h200, 11'h200);
        check("coll_inv_d1", d1, 32'h0);
        check("coll_inv_d2", d2, 32'h0);
        cyc(1'b0, '0, '0, 11'h200, 11'h200);
        check("coll_inv_new_d2", d2, 32'hDEAD_BEEF);

        // Independent ports and swap.
        cyc(1'b1, 11'h001, 32'h01, '0, '0);
        cyc(1'b1, 11'h002, 32'h02, '0, '0);
        cyc(1'b0, '0, '0, 11'h001, 11'h002);
        check("indep_d1", d1, 32'h01);
        check("indep_d2", d2, 32'h02);
        cyc(1'b0, '0, '0, 11'h002, 11'h001);
        check("swap_d1", d1, 32'h02);
        check("swap_d2", d2, 32'h01);

        // Reset mid-run drops the concurrent write and invalidates everything.
        cyc(1'b1, 11'h0FF, 32'h3C, '0, '0);
        rst = 1'b1;
        cyc(1'b1, 11'h100, 32'h77, 11'h0FF, 11'h0FF);
        check("midrst_d1", d1, 32'h0);
        check("midrst_d2", d2, 32'h0);
        rst = 1'b0;
        cyc(1'b0, '0, '0, 11'h0FF, 11'h100);
        check("after_rst_d1", d1, 32'h0);
        check("after_rst_d2", d2, 32'h0);

        // Random soak, mostly over a small window so reads hit written entries.
        for (int i = 0; i < 3000; i++) begin
            logic [AW-1:0] wa;
            logic [AW-1:0] ra;
            logic [AW-1:0] rb;
            wa = ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'($urandom_range(0, 63));
            ra = ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'($urandom_range(0, 63));
            rb = ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'($urandom_range(0, 63));
            rst = ($urandom_range(0, 499) == 0);
            cyc(1'($urandom_range(0, 1)), wa, DW'($urandom_range(0, 255)), ra, rb);
        end
        rst = 1'b0;
        cyc(1'b0, '0, '0, '0, '0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
